// File: rtl/bus_if_types_pkg.sv
// Shared bus transaction encodings and arbiter types used by rv_core and the
// slave-side fabric.
package bus_if_types_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } ttype_e;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } tsize_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_e;

    localparam logic [31:0] ARB_ERR_RDATA = 32'hDEAD_BEEF;

    // One-hot owner vector for a given arbiter state.
    function automatic logic [1:0] arb_grant_vec(input arb_state_e st);
        logic [1:0] g;
        case (st)
            OWN0:    g = 2'b01;
            OWN1:    g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bus_arbiter_2m1s_chk.sv
// Protocol checks for bus_arbiter_2m1s, attached to every instance via bind.
module bus_arbiter_2m1s_chk
    import bus_if_types_pkg::*;
(
    input logic       clk,
    input logic       rst,
    input arb_state_e state,
    input logic       m0_bstart,
    input logic       m1_bstart,
    input logic [1:0] grant
);

    a_m0_holds_bstart: assert property (@(posedge clk) disable iff (rst)
        (state == OWN0) |-> m0_bstart);

    a_m1_holds_bstart: assert property (@(posedge clk) disable iff (rst)
        (state == OWN1) |-> m1_bstart);

    a_grant_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(grant));

endmodule

bind bus_arbiter_2m1s bus_arbiter_2m1s_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .state     (state_r),
    .m0_bstart (m0_bstart),
    .m1_bstart (m1_bstart),
    .grant     (grant)
);

// File: rtl/rr_pick2.sv
// Two-way winner picker: round-robin against the last owner, or fixed
// priority to requester 1 when 'fixed' is set.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed,
    output logic       pick
);

    // Pick the winning requester index; a tie goes to the one that did not
    // own the bus last, unless priority is fixed.
    always_comb begin
        pick = 1'b0;
        case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11: begin
                if (fixed) begin
                    pick = 1'b1;
                end else begin
                    pick = ~last;
                end
            end
            default: pick = 1'b0;
        endcase
    end

endmodule

// File: rtl/bus_arbiter_2m1s.sv
// Arbitrates the core's ibus (m0) and dbus (m1) onto one shared slave bus,
// with an optional watchdog that force-completes hung slave transfers.
module bus_arbiter_2m1s
    import bus_if_types_pkg::*;
#(
    parameter int unsigned FIXED_PRIO     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = ARB_ERR_RDATA
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_breq,
    input  logic        m0_bstart,
    input  ttype_e      m0_ttype,
    input  tsize_e      m0_tsize,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_bdone,
    output logic        m0_berr,

    input  logic        m1_breq,
    input  logic        m1_bstart,
    input  ttype_e      m1_ttype,
    input  tsize_e      m1_tsize,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_bdone,
    output logic        m1_berr,

    output logic        s_breq,
    output logic        s_bstart,
    output ttype_e      s_ttype,
    output tsize_e      s_tsize,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_bdone,

    output logic [1:0]  grant
);

    localparam bit          WDOG_EN  = (TIMEOUT_CYCLES != 32'd0);
    localparam int unsigned CW       = WDOG_EN ? $clog2(TIMEOUT_CYCLES + 32'd1) : 1;
    localparam logic [CW-1:0] CNT_LAST = WDOG_EN ? CW'(TIMEOUT_CYCLES - 32'd1) : {CW{1'b0}};
    localparam logic [CW-1:0] CNT_MAX  = WDOG_EN ? CW'(TIMEOUT_CYCLES) : {CW{1'b0}};

    arb_state_e    state_r;
    arb_state_e    next_state_s;
    logic          last_grant_r;
    logic [CW-1:0] cnt_r;
    logic [1:0]    req_s;
    logic          pick_s;
    logic          timeout_s;

    assign req_s = {m1_breq & m1_bstart, m0_breq & m0_bstart};

    rr_pick2 u_pick (
        .req   (req_s),
        .last  (last_grant_r),
        .fixed (FIXED_PRIO != 32'd0),
        .pick  (pick_s)
    );

    // A slave completion in the expiry cycle wins over the watchdog.
    assign timeout_s = WDOG_EN && (state_r != IDLE) && (cnt_r == CNT_LAST) && !s_bdone;

    // Next-state: grant from IDLE, release on slave completion or expiry.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_s != 2'b00) begin
                    next_state_s = pick_s ? OWN1 : OWN0;
                end else begin
                    next_state_s = IDLE;
                end
            end
            OWN0, OWN1: begin
                if (s_bdone || timeout_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State and round-robin history registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (state_r != IDLE && next_state_s == IDLE) begin
                last_grant_r <= (state_r == OWN1);
            end
        end
    end

    // Watchdog counter: zero in the first OWN cycle, saturating thereafter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (state_r == IDLE || next_state_s == IDLE) begin
            cnt_r <= {CW{1'b0}};
        end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // Slave-side request mux and master-side response routing.
    always_comb begin
        s_breq   = 1'b0;
        s_bstart = 1'b0;
        s_ttype  = READ;
        s_tsize  = WORD;
        s_addr   = 32'h0000_0000;
        s_wdata  = 32'h0000_0000;
        m0_rdata = 32'h0000_0000;
        m0_bdone = 1'b0;
        m0_berr  = 1'b0;
        m1_rdata = 32'h0000_0000;
        m1_bdone = 1'b0;
        m1_berr  = 1'b0;
        grant    = arb_grant_vec(state_r);
        case (state_r)
            OWN0: begin
                s_breq   = 1'b1;
                s_bstart = ~timeout_s;
                s_ttype  = m0_ttype;
                s_tsize  = m0_tsize;
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                m0_bdone = s_bdone | timeout_s;
                m0_berr  = timeout_s;
                if (timeout_s) begin
                    m0_rdata = (m0_ttype == READ) ? ERR_RDATA : 32'h0000_0000;
                end else begin
                    m0_rdata = s_rdata;
                end
            end
            OWN1: begin
                s_breq   = 1'b1;
                s_bstart = ~timeout_s;
                s_ttype  = m1_ttype;
                s_tsize  = m1_tsize;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                m1_bdone = s_bdone | timeout_s;
                m1_berr  = timeout_s;
                if (timeout_s) begin
                    m1_rdata = (m1_ttype == READ) ? ERR_RDATA : 32'h0000_0000;
                end else begin
                    m1_rdata = s_rdata;
                end
            end
            default: begin
                s_breq = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter_2m1s.sv
// Directed bench: instance A is round-robin with an 8-cycle watchdog,
// instance B is fixed-priority with the watchdog disabled.
module tb_bus_arbiter_2m1s;
    import bus_if_types_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A signals
    logic a_m0_breq = 1'b0, a_m0_bstart = 1'b0, a_m1_breq = 1'b0, a_m1_bstart = 1'b0;
    ttype_e a_m0_ttype = READ, a_m1_ttype = READ, a_s_ttype;
    tsize_e a_m0_tsize = WORD, a_m1_tsize = WORD, a_s_tsize;
    logic [31:0] a_m0_addr = 32'h0, a_m0_wdata = 32'h0, a_m1_addr = 32'h0, a_m1_wdata = 32'h0;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_s_addr, a_s_wdata;
    logic [31:0] a_s_rdata = 32'h0;
    logic a_s_bdone = 1'b0;
    logic a_m0_bdone, a_m0_berr, a_m1_bdone, a_m1_berr, a_s_breq, a_s_bstart;
    logic [1:0] a_grant;

    // Instance B signals
    logic b_m0_breq = 1'b0, b_m0_bstart = 1'b0, b_m1_breq = 1'b0, b_m1_bstart = 1'b0;
    ttype_e b_m0_ttype = READ, b_m1_ttype = READ, b_s_ttype;
    tsize_e b_m0_tsize = WORD, b_m1_tsize = WORD, b_s_tsize;
    logic [31:0] b_m0_addr = 32'h0, b_m0_wdata = 32'h0, b_m1_addr = 32'h0, b_m1_wdata = 32'h0;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata;
    logic [31:0] b_s_rdata = 32'h0;
    logic b_s_bdone = 1'b0;
    logic b_m0_bdone, b_m0_berr, b_m1_bdone, b_m1_berr, b_s_breq, b_s_bstart;
    logic [1:0] b_grant;

    bus_arbiter_2m1s #(.FIXED_PRIO(0), .TIMEOUT_CYCLES(8)) dut_a (
        .clk(clk), .rst(rst),
        .m0_breq(a_m0_breq), .m0_bstart(a_m0_bstart), .m0_ttype(a_m0_ttype), .m0_tsize(a_m0_tsize),
        .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata), .m0_rdata(a_m0_rdata), .m0_bdone(a_m0_bdone),
        .m0_berr(a_m0_berr),
        .m1_breq(a_m1_breq), .m1_bstart(a_m1_bstart), .m1_ttype(a_m1_ttype), .m1_tsize(a_m1_tsize),
        .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata), .m1_rdata(a_m1_rdata), .m1_bdone(a_m1_bdone),
        .m1_berr(a_m1_berr),
        .s_breq(a_s_breq), .s_bstart(a_s_bstart), .s_ttype(a_s_ttype), .s_tsize(a_s_tsize),
        .s_addr(a_s_addr), .s_wdata(a_s_wdata), .s_rdata(a_s_rdata), .s_bdone(a_s_bdone),
        .grant(a_grant)
    );

    bus_arbiter_2m1s #(.FIXED_PRIO(1), .TIMEOUT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst),
        .m0_breq(b_m0_breq), .m0_bstart(b_m0_bstart), .m0_ttype(b_m0_ttype), .m0_tsize(b_m0_tsize),
        .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata), .m0_rdata(b_m0_rdata), .m0_bdone(b_m0_bdone),
        .m0_berr(b_m0_berr),
        .m1_breq(b_m1_breq), .m1_bstart(b_m1_bstart), .m1_ttype(b_m1_ttype), .m1_tsize(b_m1_tsize),
        .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata), .m1_rdata(b_m1_rdata), .m1_bdone(b_m1_bdone),
        .m1_berr(b_m1_berr),
        .s_breq(b_s_breq), .s_bstart(b_s_bstart), .s_ttype(b_s_ttype), .s_tsize(b_s_tsize),
        .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_rdata(b_s_rdata), .s_bdone(b_s_bdone),
        .grant(b_grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL sim_timeout observed=stalled expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    logic [1:0]  exp_rr   [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    ttype_e      wd_ttype [3] = '{READ, WRITE, READ};
    logic        wd_sdone [3] = '{1'b0, 1'b0, 1'b1};
    logic        wd_berr  [3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] wd_rdata [3] = '{32'hDEAD_BEEF, 32'h0000_0000, 32'hCAFE_0001};
    logic        wd_sbst  [3] = '{1'b0, 1'b0, 1'b1};

    initial begin
        // Reset state, with non-zero master inputs that must not leak out
        a_m0_addr = 32'h0000_0100;
        a_m0_wdata = 32'h5A5A_5A5A;
        a_s_rdata = 32'h9999_9999;
        #1 rst = 1'b1;
        #1;
        chk("rst_s_breq",   32'(a_s_breq),   32'h0);
        chk("rst_s_bstart", 32'(a_s_bstart), 32'h0);
        chk("rst_grant",    32'(a_grant),    32'h0);
        chk("rst_s_addr",   a_s_addr,        32'h0);
        chk("rst_s_wdata",  a_s_wdata,       32'h0);
        chk("rst_m0_rdata", a_m0_rdata,      32'h0);
        chk("rst_s_ttype",  32'(a_s_ttype),  32'(READ));
        chk("rst_s_tsize",  32'(a_s_tsize),  32'(WORD));
        tick();
        rst = 1'b0;
        tick();

        // m0 read, slave completes in the 3rd OWN cycle
        a_m0_breq = 1'b1; a_m0_bstart = 1'b1; a_m0_ttype = READ;
        #1;
        chk("lat_bstart_low", 32'(a_s_bstart), 32'h0);
        tick();
        chk("lat_bstart_high", 32'(a_s_bstart), 32'h1);
        chk("own0_grant",      32'(a_grant),    32'h1);
        chk("own0_addr",       a_s_addr,        32'h0000_0100);
        chk("own0_no_done",    32'(a_m0_bdone), 32'h0);
        tick();
        tick();
        a_s_rdata = 32'h1234_5678; a_s_bdone = 1'b1;
        #1;
        chk("rd_bdone",    32'(a_m0_bdone), 32'h1);
        chk("rd_rdata",    a_m0_rdata,      32'h1234_5678);
        chk("rd_berr",     32'(a_m0_berr),  32'h0);
        chk("rd_m1_bdone", 32'(a_m1_bdone), 32'h0);
        chk("rd_m1_rdata", a_m1_rdata,      32'h0);
        tick();
        a_s_bdone = 1'b0; a_m0_breq = 1'b0; a_m0_bstart = 1'b0;
        #1;
        chk("rd_pulse_end", 32'(a_m0_bdone), 32'h0);
        chk("rd_bubble",    32'(a_s_bstart), 32'h0);

        // Stray slave completion while idle
        a_s_bdone = 1'b1;
        #1;
        chk("idle_sdone_m0", 32'(a_m0_bdone), 32'h0);
        chk("idle_sdone_m1", 32'(a_m1_bdone), 32'h0);
        tick();
        chk("idle_sdone_grant", 32'(a_grant), 32'h0);
        a_s_bdone = 1'b0;

        // Round-robin with both masters held: m1, m0, m1, m0
        rst = 1'b1; #1 rst = 1'b0;
        a_m0_breq = 1'b1; a_m0_bstart = 1'b1; a_m1_breq = 1'b1; a_m1_bstart = 1'b1;
        #1;
        chk("rr_idle", 32'(a_grant), 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_grant", 32'(a_grant), 32'(exp_rr[k]));
            a_s_bdone = 1'b1;
            #1;
            chk("rr_bdone", 32'({a_m1_bdone, a_m0_bdone}), 32'(exp_rr[k]));
            tick();
            a_s_bdone = 1'b0;
            #1;
            chk("rr_bubble_grant",  32'(a_grant),    32'h0);
            chk("rr_bubble_bstart", 32'(a_s_bstart), 32'h0);
        end
        a_m0_breq = 1'b0; a_m0_bstart = 1'b0; a_m1_breq = 1'b0; a_m1_bstart = 1'b0;
        tick();

        // Watchdog: read expiry, write expiry, completion coinciding with expiry
        for (int p = 0; p < 3; p++) begin
            a_m0_ttype = wd_ttype[p]; a_s_rdata = 32'h5555_AAAA;
            a_m0_breq = 1'b1; a_m0_bstart = 1'b1;
            tick();
            chk("wd_grant", 32'(a_grant), 32'h1);
            for (int i = 2; i <= 7; i++) tick();
            chk("wd_cyc7_bdone",  32'(a_m0_bdone), 32'h0);
            chk("wd_cyc7_bstart", 32'(a_s_bstart), 32'h1);
            tick();
            a_s_bdone = wd_sdone[p]; a_s_rdata = 32'hCAFE_0001;
            #1;
            chk("wd_bdone",  32'(a_m0_bdone), 32'h1);
            chk("wd_berr",   32'(a_m0_berr),  32'(wd_berr[p]));
            chk("wd_rdata",  a_m0_rdata,      wd_rdata[p]);
            chk("wd_bstart", 32'(a_s_bstart), 32'(wd_sbst[p]));
            tick();
            a_s_bdone = 1'b0; a_m0_breq = 1'b0; a_m0_bstart = 1'b0;
            #1;
            chk("wd_after_bdone", 32'(a_m0_bdone), 32'h0);
            chk("wd_after_grant", 32'(a_grant),    32'h0);
        end

        // m1-only transfer so round-robin history points at m1
        a_m1_breq = 1'b1; a_m1_bstart = 1'b1; a_m1_addr = 32'h0000_0800;
        tick();
        chk("m1only_grant", 32'(a_grant), 32'h2);
        a_s_bdone = 1'b1;
        tick();
        a_s_bdone = 1'b0;
        #1;
        chk("m1only_bubble", 32'(a_grant), 32'h0);
        // m1 stays requesting; reset lands 2 cycles into OWN1
        tick();
        chk("own1_c1", 32'(a_grant), 32'h2);
        tick();
        a_m0_breq = 1'b1; a_m0_bstart = 1'b1; a_s_rdata = 32'h7777_7777;
        rst = 1'b1;
        #1;
        chk("arst_grant",    32'(a_grant),    32'h0);
        chk("arst_s_breq",   32'(a_s_breq),   32'h0);
        chk("arst_s_bstart", 32'(a_s_bstart), 32'h0);
        chk("arst_s_addr",   a_s_addr,        32'h0);
        chk("arst_m1_rdata", a_m1_rdata,      32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_idle", 32'(a_grant), 32'h0);
        tick();
        chk("post_rst_tie_m1", 32'(a_grant), 32'h2);
        a_s_bdone = 1'b1;
        tick();
        a_s_bdone = 1'b0;
        a_m0_breq = 1'b0; a_m0_bstart = 1'b0; a_m1_breq = 1'b0; a_m1_bstart = 1'b0;

        // Instance B: fixed priority, m1 writes a byte to an odd address
        b_m1_breq = 1'b1; b_m1_bstart = 1'b1; b_m1_ttype = WRITE; b_m1_tsize = BYTE;
        b_m1_addr = 32'h2000_0003; b_m1_wdata = 32'h0000_00AB;
        b_m0_breq = 1'b1; b_m0_bstart = 1'b1; b_m0_ttype = READ; b_m0_tsize = WORD;
        b_m0_addr = 32'h0000_0040; b_m0_wdata = 32'h1111_1111;
        #1;
        chk("fx_idle", 32'(b_grant), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fx_grant_m1", 32'(b_grant), 32'h2);
            if (k == 0) begin
                chk("wr_ttype", 32'(b_s_ttype), 32'(WRITE));
                chk("wr_tsize", 32'(b_s_tsize), 32'(BYTE));
                chk("wr_addr",  b_s_addr,       32'h2000_0003);
                chk("wr_wdata", b_s_wdata,      32'h0000_00AB);
            end
            b_s_rdata = 32'h7777_0000; b_s_bdone = 1'b1;
            #1;
            chk("fx_m1_bdone", 32'(b_m1_bdone), 32'h1);
            chk("fx_m0_bdone", 32'(b_m0_bdone), 32'h0);
            chk("fx_m0_rdata", b_m0_rdata,      32'h0);
            tick();
            b_s_bdone = 1'b0;
            #1;
            chk("fx_bubble", 32'(b_grant), 32'h0);
        end
        b_m1_breq = 1'b0; b_m1_bstart = 1'b0;
        tick();
        chk("fx_grant_m0", 32'(b_grant),   32'h1);
        chk("fx_m0_addr",  b_s_addr,       32'h0000_0040);
        chk("fx_m0_ttype", 32'(b_s_ttype), 32'(READ));
        // Watchdog disabled: a silent slave keeps the grant indefinitely
        for (int i = 0; i < 12; i++) tick();
        chk("nowd_grant", 32'(b_grant),    32'h1);
        chk("nowd_bdone", 32'(b_m0_bdone), 32'h0);
        b_s_rdata = 32'h0BAD_F00D; b_s_bdone = 1'b1;
        #1;
        chk("nowd_done",  32'(b_m0_bdone), 32'h1);
        chk("nowd_rdata", b_m0_rdata,      32'h0BAD_F00D);
        tick();
        b_s_bdone = 1'b0; b_m0_breq = 1'b0; b_m0_bstart = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
